// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan controller.
//   - 7-bit glyph constants, ordered {a,b,c,d,e,f,g} (bit 6 = segment a),
//     active-high (a set bit lights the segment).
//   - Scan FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to 7-segment glyph.
//   nibble_i  in  4   BCD digit; values 10..15 are shown as a dash
//   seg_o     out 7   {a,b,c,d,e,f,g}, active-high
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: time-multiplexes NUM_DIGITS BCD digits onto one
// shared 7-segment bus with one-hot digit enables.
//   clk          in   1             rising-edge clock
//   reset_n      in   1             asynchronous assert, active-low
//   load         in   1             capture data_in/blank_mask into shadow
//   data_in      in   4*NUM_DIGITS  BCD nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask   in   NUM_DIGITS    1 = force that digit dark
//   lz_blank     in   1             leading-zero blanking enable (live)
//   pending      out  1             shadow not yet committed to display
//   frame_start  out  1             pulse as digit 0's ON slot begins
//   seg_out      out  7             {a..g}, inverted when SEG_ACTIVE_LOW
//   digit_en     out  NUM_DIGITS    one-hot, inverted when DIG_ACTIVE_LOW
// New data is committed from shadow to display only at a frame boundary so
// a frame is never torn. Outputs are computed from next-state values and
// registered, so they line up exactly with the FSM state.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank,
    output logic                    pending,
    output logic                    frame_start,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int CNT_MAX_A = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int IDX_W     = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]     shadow_mask_q, shadow_mask_d;
    logic [4*NUM_DIGITS-1:0]   disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]     disp_mask_q, disp_mask_d;
    logic                      pending_q, pending_d;
    logic                      frame_q, frame_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     dig_q, dig_d;

    logic                      slot_start;
    logic                      commit;
    logic [3:0]                nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     dig_onehot;
    logic [NUM_DIGITS-1:0]     lz_vec;
    logic                      lz_run;
    logic [3:0]                cur_nib;
    logic [6:0]                cur_glyph;
    logic                      dark;

    // Scan FSM: slot_start marks the first cycle of any ON slot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        slot_start = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                    state_d    = ST_ON;
                    cnt_d      = '0;
                    slot_start = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d = '0;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        state_d = ST_BLANK;
                    end else begin
                        slot_start = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow/display pair. On a commit the old shadow moves to display while
    // a simultaneous load refills the shadow, leaving pending set.
    always_comb begin
        frame_d       = slot_start && (idx_d == '0);
        commit        = frame_d && pending_q;
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        disp_data_d   = disp_data_q;
        disp_mask_d   = disp_mask_q;
        pending_d     = pending_q;
        if (commit) begin
            disp_data_d = shadow_data_q;
            disp_mask_d = shadow_mask_q;
            pending_d   = 1'b0;
        end
        if (load) begin
            shadow_data_d = data_in;
            shadow_mask_d = blank_mask;
            pending_d     = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]        = disp_data_d[gi*4 +: 4];
            assign dig_onehot[gi] = (idx_d == IDX_W'(gi));
        end
    endgenerate

    // lz_vec[i] = 1 when digit i and every digit above it are zero.
    always_comb begin
        lz_run = 1'b1;
        lz_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run    = lz_run & (disp_data_d[i*4 +: 4] == 4'd0);
            lz_vec[i] = lz_run;
        end
    end

    assign cur_nib = nib[idx_d];

    seg7_decode u_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_glyph)
    );

    // Digit 0 is never leading-zero blanked so a zero value still shows "0".
    always_comb begin
        dark  = disp_mask_d[idx_d] | (lz_blank & lz_vec[idx_d] & (idx_d != '0));
        seg_d = SEG_OFF;
        dig_d = '0;
        if (state_d == ST_ON) begin
            dig_d = dig_onehot;
            if (!dark) begin
                seg_d = cur_glyph;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            disp_data_q   <= '0;
            disp_mask_q   <= '0;
            pending_q     <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= SEG_OFF;
            dig_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            disp_data_q   <= disp_data_d;
            disp_mask_q   <= disp_mask_d;
            pending_q     <= pending_d;
            frame_q       <= frame_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_q;
    assign seg_out     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign digit_en    = DIG_ACTIVE_LOW ? ~dig_q : dig_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
module tb_seg7_scan_controller;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G6 = 7'b1011111;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] GD = 7'b0000001;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic        lz_blank;
    logic        pending;
    logic        frame_start;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;

    int n_cmp;
    int n_fail;

    seg7_scan_controller #(
        .NUM_DIGITS     (4),
        .TICK_DIV       (4),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .data_in     (data_in),
        .blank_mask  (blank_mask),
        .lz_blank    (lz_blank),
        .pending     (pending),
        .frame_start (frame_start),
        .seg_out     (seg_out),
        .digit_en    (digit_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        load = 1'b1; data_in = d; blank_mask = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    // Captures one frame: samples each digit at the first cycle of its slot
    // (slots start 6 cycles apart: 4 ON + 2 BLANK).
    task automatic grab_frame(output bit ok, output logic pend0,
                              output logic [27:0] segs, output logic [15:0] ens);
        segs = '0; ens = '0; pend0 = 1'bx;
        wait_fs(ok);
        if (ok) begin
            pend0 = pending;
            for (int d = 0; d < 4; d++) begin
                if (d > 0) repeat (6) @(negedge clk);
                segs[d*7 +: 7] = seg_out;
                ens[d*4 +: 4]  = digit_en;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_en [8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        logic       exp_fs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        reset_n = 1'b0; load = 1'b0; data_in = '0; blank_mask = '0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (seg_out !== 7'b0) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seg_out, 7'b0); end
        n_cmp++; if (digit_en !== 4'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=%b", digit_en, 4'b0); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (digit_en !== exp_en[k]) begin n_fail++; $display("FAIL timing_en k=%0d got=%b exp=%b", k, digit_en, exp_en[k]); end
            n_cmp++;
            if (frame_start !== exp_fs[k]) begin n_fail++; $display("FAIL timing_fs k=%0d got=%b exp=%b", k, frame_start, exp_fs[k]); end
            if (k == 1) begin
                n_cmp++;
                if (seg_out !== G0) begin n_fail++; $display("FAIL timing_seg got=%b exp=%b", seg_out, G0); end
            end
        end
        $display("test_reset: done (%0d compared)", n_cmp);
    endtask

    task automatic check_frame(input string name, input logic [6:0] exp_seg [4],
                               input logic exp_pend0, input bit chk_pend);
        bit ok; logic pend0; logic [27:0] segs; logic [15:0] ens;
        grab_frame(ok, pend0, segs, ens);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL %s_timeout got=no_frame_start exp=frame_start", name); end
        if (chk_pend) begin
            n_cmp++;
            if (pend0 !== exp_pend0) begin n_fail++; $display("FAIL %s_pending got=%b exp=%b", name, pend0, exp_pend0); end
        end
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (segs[d*7 +: 7] !== exp_seg[d]) begin n_fail++; $display("FAIL %s_seg d=%0d got=%b exp=%b", name, d, segs[d*7 +: 7], exp_seg[d]); end
            n_cmp++;
            if (ens[d*4 +: 4] !== (4'b0001 << d)) begin n_fail++; $display("FAIL %s_en d=%0d got=%b exp=%b", name, d, ens[d*4 +: 4], 4'b0001 << d); end
        end
        $display("%s: frame checked (%0d compared)", name, n_cmp);
    endtask

    task automatic test_load_commit;
        logic [6:0] e [4] = '{G4, G3, G2, G1};
        do_load(16'h1234, 4'b0000);
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending got=%b exp=1", pending); end
        check_frame("load_commit", e, 1'b0, 1'b1);
    endtask

    task automatic test_lz;
        logic [6:0] e_on  [4] = '{G0, G7, 7'b0, 7'b0};
        logic [6:0] e_off [4] = '{G0, G7, G0, G0};
        lz_blank = 1'b1;
        do_load(16'h0070, 4'b0000);
        check_frame("lz_on", e_on, 1'b0, 1'b1);
        lz_blank = 1'b0;
        check_frame("lz_off", e_off, 1'b0, 1'b0);
    endtask

    task automatic test_blank_mask;
        logic [6:0] e [4] = '{G8, G8, 7'b0, G8};
        do_load(16'h8888, 4'b0100);
        check_frame("mask", e, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [6:0] e [4] = '{G2, G2, G2, G2};
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got=no_frame_start exp=frame_start"); end
        load = 1'b1; data_in = 16'h1111; blank_mask = 4'b0000;
        @(negedge clk);
        data_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pending got=%b exp=1", pending); end
        check_frame("b2b_first", e, 1'b0, 1'b1);
        check_frame("b2b_second", e, 1'b0, 1'b1);
    endtask

    task automatic test_load_on_commit;
        bit ok;
        logic [6:0] ea [4] = '{G8, G7, G6, G5};
        logic [6:0] eb [4] = '{G3, GD, G0, G0};
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL loc_timeout got=no_frame_start exp=frame_start"); end
        repeat (2) @(negedge clk);
        load = 1'b1; data_in = 16'h5678; blank_mask = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        // Next edge is the frame boundary: this load coincides with the commit.
        load = 1'b1; data_in = 16'h00C3;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL loc_fs got=%b exp=1", frame_start); end
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL loc_pending got=%b exp=1", pending); end
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (6) @(negedge clk);
            n_cmp++;
            if (seg_out !== ea[d]) begin n_fail++; $display("FAIL loc_old_seg d=%0d got=%b exp=%b", d, seg_out, ea[d]); end
            n_cmp++;
            if (digit_en !== (4'b0001 << d)) begin n_fail++; $display("FAIL loc_old_en d=%0d got=%b exp=%b", d, digit_en, 4'b0001 << d); end
        end
        check_frame("loc_new", eb, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [6:0] e [4] = '{G0, G0, G0, G0};
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout got=no_frame_start exp=frame_start"); end
        load = 1'b1; data_in = 16'h4321; blank_mask = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rmid_pending_pre got=%b exp=1", pending); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (seg_out !== 7'b0) begin n_fail++; $display("FAIL rmid_seg got=%b exp=%b", seg_out, 7'b0); end
        n_cmp++; if (digit_en !== 4'b0) begin n_fail++; $display("FAIL rmid_en got=%b exp=%b", digit_en, 4'b0); end
        n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got=%b exp=0", pending); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rmid_fs got=%b exp=0", frame_start); end
        @(negedge clk);
        reset_n = 1'b1;
        check_frame("rmid_after", e, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_load_commit();
        test_lz();
        test_blank_mask();
        test_back_to_back();
        test_load_on_commit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
